rf_mp: RTL

RF_MP -- requirements
Module: rf_mp

---
 rtl/rf_mp.sv | 112 +++++++++++
 1 files changed

// File: rtl/rf_mp.sv
// Multi-port register file: one write port, N_RD registered read ports,
// optional write-to-read forwarding, optional hard-wired zero entry, and a sequential clear.
module rf_mp #(
  parameter int unsigned BW       = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   chip_en,
  input  logic                   write_en_n,
  input  logic [AW-1:0]          write_addr,
  input  logic signed [BW-1:0]   data_in,
  input  logic [N_RD-1:0]        rd_en,
  input  logic [N_RD*AW-1:0]     read_addr,
  output logic [N_RD*BW-1:0]     data_out,
  output logic [N_RD-1:0]        data_valid,
  input  logic                   init_req,
  output logic                   init_busy
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       mem_q [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [BW-1:0]       mem_wdata;
  logic                user_wr;
  logic [N_RD*BW-1:0]  data_out_q, data_out_d;
  logic [N_RD-1:0]     data_valid_q, data_valid_d;
  logic                init_busy_q, init_busy_d;

  // Next state, clear sequencing, user write qualification and read muxing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = write_addr;
    mem_wdata    = data_in;
    data_out_d   = data_out_q;
    data_valid_d = '0;
    user_wr      = chip_en && !write_en_n &&
                   !((ZERO_REG != 0) && (write_addr == '0));
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        mem_we = user_wr;
        for (int i = 0; i < int'(N_RD); i++) begin
          if (chip_en && rd_en[i]) begin
            data_valid_d[i] = 1'b1;
            // Zero entry wins over forwarding; forwarding wins over stored contents.
            if ((ZERO_REG != 0) && (read_addr[i*AW +: AW] == '0))
              data_out_d[i*BW +: BW] = '0;
            else if ((BYPASS != 0) && user_wr && (read_addr[i*AW +: AW] == write_addr))
              data_out_d[i*BW +: BW] = data_in;
            else
              data_out_d[i*BW +: BW] = mem_q[read_addr[i*AW +: AW]];
          end
        end
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    init_busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= '0;
      init_busy_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      init_busy_q  <= init_busy_d;
    end
  end

  // Storage is not reset; it only becomes zero through the clear sequence.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign init_busy  = init_busy_q;

endmodule
